// File: rtl/aggregation_block.sv
// -----------------------------------------------------------------------------
// aggregation_block
//
// Purpose:
//   Graph aggregation stage. After the transformation stage has produced the
//   FM*WM product (one row per graph node), this block sums product rows into
//   a bank of FEATURE_ROWS x WEIGHT_COLS accumulators, following a COO edge
//   list: for every edge (src -> dst) the product row of src is added into the
//   accumulator row of dst. With the self-loop phase enabled every node also
//   receives its own product row first (A + I aggregation).
//
// Configuration macro:
//   AGG_SELF_LOOP_EN  defined   -> SELF phase present, latency 2 + FEATURE_ROWS + 2*edges
//                     undefined -> no SELF phase, latency 2 + 2*edges
//
// Ports:
//   clk              in   single clock, rising edge
//   reset            in   asynchronous active-low reset
//   start            in   one-cycle start pulse (accepted only in IDLE)
//   num_edges[4:0]   in   edge count, sampled on an accepted start, clamped to MAX_EDGES
//   coo_read_en      out  COO memory read strobe
//   coo_read_address out  edge index being fetched
//   coo_in[5:0]      in   {src[5:3], dst[2:0]}, valid the cycle after coo_read_en
//   read_row[2:0]    out  row select into the FM*WM product memory
//   fm_wm_row_in     in   product row (WEIGHT_COLS x DOT_PROD_WIDTH), combinational on read_row
//   out_row_sel[2:0] in   external accumulator row select
//   agg_row_out      out  accumulator row at out_row_sel (WEIGHT_COLS x AGG_WIDTH), combinational
//   busy             out  high whenever the FSM is not in IDLE
//   done             out  one-cycle completion pulse
//   err_bad_edge     out  sticky: an edge referenced a node index >= FEATURE_ROWS
//   state_dbg[2:0]   out  current FSM state, for observation only
//
// Handshake: start is a single-cycle request with no ready; it is taken only
// when busy is low and silently dropped otherwise. done is a single-cycle
// completion pulse; agg_row_out is final from the done cycle until the next
// accepted start. Column c of any packed row lives at [c*WIDTH +: WIDTH].
// -----------------------------------------------------------------------------
module aggregation_block #(
    parameter int FEATURE_ROWS   = 6,
    parameter int WEIGHT_COLS    = 3,
    parameter int DOT_PROD_WIDTH = 16,
    parameter int MAX_EDGES      = 16,
    parameter int AGG_WIDTH      = 21
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  start,
    input  logic [4:0]                            num_edges,
    output logic                                  coo_read_en,
    output logic [3:0]                            coo_read_address,
    input  logic [5:0]                            coo_in,
    output logic [2:0]                            read_row,
    input  logic [DOT_PROD_WIDTH*WEIGHT_COLS-1:0] fm_wm_row_in,
    input  logic [2:0]                            out_row_sel,
    output logic [AGG_WIDTH*WEIGHT_COLS-1:0]      agg_row_out,
    output logic                                  busy,
    output logic                                  done,
    output logic                                  err_bad_edge,
    output logic [2:0]                            state_dbg
);

    // FSM encoding
    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_CLEAR    = 3'd1;
`ifdef AGG_SELF_LOOP_EN
    localparam logic [2:0] S_SELF     = 3'd2;
`endif
    localparam logic [2:0] S_EDGE_REQ = 3'd3;
    localparam logic [2:0] S_EDGE_ACC = 3'd4;
    localparam logic [2:0] S_DONE     = 3'd5;

    localparam logic [3:0] ROWS_L   = 4'(FEATURE_ROWS);
    localparam logic [4:0] MAX_E    = 5'(MAX_EDGES);
`ifdef AGG_SELF_LOOP_EN
    localparam logic [2:0] LAST_ROW = 3'(FEATURE_ROWS - 1);
`endif

    logic [2:0]           state;
    logic [4:0]           edge_count;   // clamped edge count for this run
    logic [4:0]           edge_idx;     // next edge to fetch / edge being accumulated
    logic                 err_q;
`ifdef AGG_SELF_LOOP_EN
    logic [2:0]           row_cnt;      // SELF phase row pointer
`endif
    logic [AGG_WIDTH-1:0] acc [FEATURE_ROWS][WEIGHT_COLS];

    // Product row split into columns and zero-extended to accumulator width.
    logic [AGG_WIDTH-1:0] prod_ext [WEIGHT_COLS];

    always_comb begin
        for (int c = 0; c < WEIGHT_COLS; c++) begin
            prod_ext[c] = AGG_WIDTH'(fm_wm_row_in[c*DOT_PROD_WIDTH +: DOT_PROD_WIDTH]);
        end
    end

    // Edge decode: coo_in carries the edge requested in the previous cycle.
    logic [2:0] edge_src;
    logic [2:0] edge_dst;
    logic       edge_ok;
    logic [4:0] edge_next;
    logic [4:0] edges_clamped;

    assign edge_src      = coo_in[5:3];
    assign edge_dst      = coo_in[2:0];
    assign edge_ok       = ({1'b0, edge_src} < ROWS_L) && ({1'b0, edge_dst} < ROWS_L);
    assign edge_next     = edge_idx + 5'd1;
    assign edges_clamped = (num_edges > MAX_E) ? MAX_E : num_edges;

    // Main sequential block: FSM, counters, accumulators.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            edge_count <= '0;
            edge_idx   <= '0;
            err_q      <= 1'b0;
`ifdef AGG_SELF_LOOP_EN
            row_cnt    <= '0;
`endif
            for (int r = 0; r < FEATURE_ROWS; r++) begin
                for (int c = 0; c < WEIGHT_COLS; c++) begin
                    acc[r][c] <= '0;
                end
            end
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state      <= S_CLEAR;
                        edge_count <= edges_clamped;
                        err_q      <= 1'b0;
                    end
                end

                S_CLEAR: begin
                    for (int r = 0; r < FEATURE_ROWS; r++) begin
                        for (int c = 0; c < WEIGHT_COLS; c++) begin
                            acc[r][c] <= '0;
                        end
                    end
                    edge_idx <= '0;
`ifdef AGG_SELF_LOOP_EN
                    row_cnt  <= '0;
                    state    <= S_SELF;
`else
                    state    <= (edge_count != 5'd0) ? S_EDGE_REQ : S_DONE;
`endif
                end

`ifdef AGG_SELF_LOOP_EN
                S_SELF: begin
                    // Identity term: each node adds its own product row once.
                    for (int c = 0; c < WEIGHT_COLS; c++) begin
                        acc[row_cnt][c] <= acc[row_cnt][c] + prod_ext[c];
                    end
                    if (row_cnt == LAST_ROW) begin
                        row_cnt <= '0;
                        state   <= (edge_count != 5'd0) ? S_EDGE_REQ : S_DONE;
                    end else begin
                        row_cnt <= row_cnt + 3'd1;
                    end
                end
`endif

                S_EDGE_REQ: begin
                    state <= S_EDGE_ACC;
                end

                S_EDGE_ACC: begin
                    // A malformed edge is skipped but still consumes its slot,
                    // so the run length depends only on the edge count.
                    if (edge_ok) begin
                        for (int c = 0; c < WEIGHT_COLS; c++) begin
                            acc[edge_dst][c] <= acc[edge_dst][c] + prod_ext[c];
                        end
                    end else begin
                        err_q <= 1'b1;
                    end
                    edge_idx <= edge_next;
                    state    <= (edge_next < edge_count) ? S_EDGE_REQ : S_DONE;
                end

                S_DONE: begin
                    state <= S_IDLE;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Decoded outputs
    assign busy             = (state != S_IDLE);
    assign done             = (state == S_DONE);
    assign coo_read_en      = (state == S_EDGE_REQ);
    assign coo_read_address = edge_idx[3:0];
    assign err_bad_edge     = err_q;
    assign state_dbg        = state;

    // Product memory row select: own row in SELF, edge source in EDGE_ACC,
    // zero everywhere else.
    always_comb begin
        read_row = 3'd0;
        case (state)
`ifdef AGG_SELF_LOOP_EN
            S_SELF:     read_row = row_cnt;
`endif
            S_EDGE_ACC: read_row = edge_src;
            default:    read_row = 3'd0;
        endcase
    end

    // External read port; rows beyond the node count read as zero.
    always_comb begin
        agg_row_out = '0;
        if ({1'b0, out_row_sel} < ROWS_L) begin
            for (int c = 0; c < WEIGHT_COLS; c++) begin
                agg_row_out[c*AGG_WIDTH +: AGG_WIDTH] = acc[out_row_sel][c];
            end
        end
    end

endmodule

// File: tb/tb_aggregation_block.sv
// -----------------------------------------------------------------------------
// tb_aggregation_block
//
// Bench for aggregation_block. A directed vector table covers the documented
// scenarios, followed by an abort-by-reset sequence and randomized runs. The
// expected accumulator contents come from a sum-over-edges reference model;
// latency expectations come from the closed-form run-length formula.
// Works with AGG_SELF_LOOP_EN either defined or undefined.
// -----------------------------------------------------------------------------
module tb_aggregation_block;

    localparam int R = 6;
    localparam int C = 3;
    localparam int W = 16;
    localparam int A = 21;

`ifdef AGG_SELF_LOOP_EN
    localparam bit SELF_EN = 1'b1;
`else
    localparam bit SELF_EN = 1'b0;
`endif

    // ---------------- clock / reset / DUT ----------------
    logic           clk;
    logic           reset;
    logic           start;
    logic [4:0]     num_edges;
    logic           coo_read_en;
    logic [3:0]     coo_read_address;
    logic [5:0]     coo_in;
    logic [2:0]     read_row;
    logic [W*C-1:0] fm_wm_row_in;
    logic [2:0]     out_row_sel;
    logic [A*C-1:0] agg_row_out;
    logic           busy;
    logic           done;
    logic           err_bad_edge;
    logic [2:0]     state_dbg;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    aggregation_block #(
        .FEATURE_ROWS(R), .WEIGHT_COLS(C), .DOT_PROD_WIDTH(W), .MAX_EDGES(16), .AGG_WIDTH(A)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .num_edges(num_edges),
        .coo_read_en(coo_read_en), .coo_read_address(coo_read_address), .coo_in(coo_in),
        .read_row(read_row), .fm_wm_row_in(fm_wm_row_in), .out_row_sel(out_row_sel),
        .agg_row_out(agg_row_out), .busy(busy), .done(done), .err_bad_edge(err_bad_edge),
        .state_dbg(state_dbg)
    );

    // ---------------- memory responders ----------------
    // Rows 6/7 hold a marker so a stray read of an invalid row corrupts sums.
    logic [W-1:0] prod_mem [8][C];
    logic [5:0]   coo_mem  [16];

    always_comb begin
        fm_wm_row_in = '0;
        for (int c = 0; c < C; c++) fm_wm_row_in[c*W +: W] = prod_mem[read_row][c];
    end

    // One-cycle read latency; outside a read the bus shows an invalid edge.
    always @(posedge clk) coo_in <= coo_read_en ? coo_mem[coo_read_address] : 6'h3F;

    // ---------------- scoreboard ----------------
    int total = 0;
    int bad   = 0;
    logic [A-1:0] exp_q[$];

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [5:0] ed(input int s, input int d);
        return 6'(s * 8 + d);
    endfunction

    // Reference model: every node starts at its own row (if self loops are on),
    // then each valid edge adds the source row to the destination row.
    task automatic model_push(input int n, output int lat, output bit err);
        longint m [R][C];
        int n_eff;
        int s, d;
        n_eff = (n > 16) ? 16 : n;
        err = 1'b0;
        for (int r = 0; r < R; r++)
            for (int c = 0; c < C; c++)
                m[r][c] = SELF_EN ? longint'(prod_mem[r][c]) : 0;
        for (int k = 0; k < n_eff; k++) begin
            s = int'(coo_mem[k][5:3]);
            d = int'(coo_mem[k][2:0]);
            if (s < R && d < R) begin
                for (int c = 0; c < C; c++) m[d][c] += longint'(prod_mem[s][c]);
            end else begin
                err = 1'b1;
            end
        end
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < C; c++)
                exp_q.push_back((r < R) ? A'(m[r][c]) : '0);
        lat = 2 + (SELF_EN ? R : 0) + 2 * n_eff;
    endtask

    task automatic read_all_check(input string tag);
        logic [A-1:0] e;
        for (int r = 0; r < 8; r++) begin
            out_row_sel = 3'(r);
            #1;
            for (int c = 0; c < C; c++) begin
                e = exp_q.pop_front();
                chk($sformatf("%s_row%0d_col%0d", tag, r, c), longint'(agg_row_out[c*A +: A]), longint'(e));
            end
        end
    endtask

    task automatic check_all_zero(input string tag);
        for (int r = 0; r < 8; r++) begin
            out_row_sel = 3'(r);
            #1;
            for (int c = 0; c < C; c++)
                chk($sformatf("%s_row%0d_col%0d", tag, r, c), longint'(agg_row_out[c*A +: A]), 0);
        end
    endtask

    // ---------------- driver ----------------
    task automatic load_kind(input int kind);
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < C; c++) begin
                if (r >= R)         prod_mem[r][c] = 16'hBEEF;
                else if (kind == 0) prod_mem[r][c] = W'(c + 1);
                else if (kind == 1) prod_mem[r][c] = W'(r);
                else if (kind == 2) prod_mem[r][c] = 16'hFFFF;
                else                prod_mem[r][c] = W'($urandom_range(0, 65535));
            end
    endtask

    // Start a run, poke a second start while busy (must be ignored), and
    // count cycles from the accepting edge until done is seen.
    task automatic run_op(input string tag, input int n, output int lat);
        bit got;
        bit busy_ok;
        @(negedge clk);
        num_edges = 5'(n);
        start = 1'b1;
        @(negedge clk);
        lat = 1;
        got = done;
        busy_ok = busy;
        num_edges = 5'd0;
        while (!got && lat < 300) begin
            @(negedge clk);
            start = 1'b0;
            lat++;
            if (done) got = 1'b1;
            else if (!busy) busy_ok = 1'b0;
        end
        start = 1'b0;
        if (!got) $display("FAIL %s_timeout: no done within %0d cycles, state %0d", tag, lat, state_dbg);
        chk({tag, "_busy_held"}, busy_ok, 1);
        @(negedge clk);
        chk({tag, "_done_one_cycle"}, done, 0);
        chk({tag, "_idle_after"}, busy, 0);
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        int         kind;
        int         n;
        logic [5:0] e [16];
        int         exp_lat;
        bit         exp_err;
        int         chk_row;
        int         chk_val;
    } vec_t;

    localparam int NV = 8;
    vec_t tbl [NV];

    initial begin
        int lat, mlat;
        bit merr;
        bit found, seen;

        for (int i = 0; i < NV; i++)
            for (int k = 0; k < 16; k++) tbl[i].e[k] = ed(7, 7);

        // all rows {1,2,3}, no edges
        tbl[0].kind = 0; tbl[0].n = 0;
        tbl[0].exp_lat = SELF_EN ? 8 : 2; tbl[0].exp_err = 0;
        tbl[0].chk_row = 3; tbl[0].chk_val = SELF_EN ? 1 : 0;
        // row r = {r,r,r}, three edges into node 1
        tbl[1].kind = 1; tbl[1].n = 3;
        tbl[1].e[0] = ed(0, 1); tbl[1].e[1] = ed(2, 1); tbl[1].e[2] = ed(5, 1);
        tbl[1].exp_lat = SELF_EN ? 14 : 8; tbl[1].exp_err = 0;
        tbl[1].chk_row = 1; tbl[1].chk_val = SELF_EN ? 8 : 7;
        // all 0xFFFF, sixteen 0->0 edges: widest possible sum
        tbl[2].kind = 2; tbl[2].n = 16;
        for (int k = 0; k < 16; k++) tbl[2].e[k] = ed(0, 0);
        tbl[2].exp_lat = SELF_EN ? 40 : 34; tbl[2].exp_err = 0;
        tbl[2].chk_row = 0; tbl[2].chk_val = SELF_EN ? 1114095 : 1048560;
        // bad source among valid edges
        tbl[3].kind = 1; tbl[3].n = 3;
        tbl[3].e[0] = ed(1, 2); tbl[3].e[1] = ed(7, 2); tbl[3].e[2] = ed(3, 2);
        tbl[3].exp_lat = SELF_EN ? 14 : 8; tbl[3].exp_err = 1;
        tbl[3].chk_row = 2; tbl[3].chk_val = SELF_EN ? 6 : 4;
        // single edge 3->4 (error flag from previous run must clear)
        tbl[4].kind = 1; tbl[4].n = 1;
        tbl[4].e[0] = ed(3, 4);
        tbl[4].exp_lat = SELF_EN ? 10 : 4; tbl[4].exp_err = 0;
        tbl[4].chk_row = 4; tbl[4].chk_val = SELF_EN ? 7 : 3;
        // edge count 20 clamps to 16
        tbl[5].kind = 1; tbl[5].n = 20;
        for (int k = 0; k < 16; k++) tbl[5].e[k] = ed(2, 5);
        tbl[5].exp_lat = SELF_EN ? 40 : 34; tbl[5].exp_err = 0;
        tbl[5].chk_row = 5; tbl[5].chk_val = SELF_EN ? 37 : 32;
        // duplicated self edge
        tbl[6].kind = 1; tbl[6].n = 2;
        tbl[6].e[0] = ed(4, 4); tbl[6].e[1] = ed(4, 4);
        tbl[6].exp_lat = SELF_EN ? 12 : 6; tbl[6].exp_err = 0;
        tbl[6].chk_row = 4; tbl[6].chk_val = SELF_EN ? 12 : 8;
        // bad destination, then a valid edge
        tbl[7].kind = 1; tbl[7].n = 2;
        tbl[7].e[0] = ed(1, 6); tbl[7].e[1] = ed(2, 0);
        tbl[7].exp_lat = SELF_EN ? 12 : 6; tbl[7].exp_err = 1;
        tbl[7].chk_row = 0; tbl[7].chk_val = 2;

        // ---------------- reset state ----------------
        reset = 1'b0; start = 1'b0; num_edges = '0; out_row_sel = '0;
        load_kind(0);
        for (int k = 0; k < 16; k++) coo_mem[k] = ed(7, 7);
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err_bad_edge, 0);
        chk("rst_coo_en", coo_read_en, 0);
        chk("rst_coo_addr", coo_read_address, 0);
        chk("rst_read_row", read_row, 0);
        check_all_zero("rst");
        reset = 1'b1;
        @(negedge clk);

        // ---------------- table ----------------
        for (int i = 0; i < NV; i++) begin
            load_kind(tbl[i].kind);
            for (int k = 0; k < 16; k++) coo_mem[k] = tbl[i].e[k];
            model_push(tbl[i].n, mlat, merr);
            run_op($sformatf("vec%0d", i), tbl[i].n, lat);
            chk($sformatf("vec%0d_latency", i), lat, tbl[i].exp_lat);
            chk($sformatf("vec%0d_err", i), err_bad_edge, tbl[i].exp_err);
            chk($sformatf("vec%0d_read_row_idle", i), read_row, 0);
            out_row_sel = 3'(tbl[i].chk_row);
            #1;
            chk($sformatf("vec%0d_key_value", i), longint'(agg_row_out[A-1:0]), tbl[i].chk_val);
            read_all_check($sformatf("vec%0d", i));
        end

        // ---------------- reset during EDGE_ACC of edge 3 ----------------
        load_kind(1);
        coo_mem[0] = ed(0, 1); coo_mem[1] = ed(7, 1); coo_mem[2] = ed(2, 3);
        coo_mem[3] = ed(4, 5); coo_mem[4] = ed(5, 0); coo_mem[5] = ed(1, 1);
        @(negedge clk);
        num_edges = 5'd6;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 100 && !found; k++) begin
            @(negedge clk);
            if (coo_read_en && coo_read_address == 4'd3) found = 1'b1;
        end
        chk("abort_reached_edge3", found, 1);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_err", err_bad_edge, 0);
        chk("abort_coo_en", coo_read_en, 0);
        chk("abort_coo_addr", coo_read_address, 0);
        chk("abort_read_row", read_row, 0);
        check_all_zero("abort");
        seen = 1'b0;
        repeat (3) begin @(negedge clk); if (done || busy) seen = 1'b1; end
        reset = 1'b1;
        repeat (4) begin @(negedge clk); if (done || busy) seen = 1'b1; end
        chk("abort_no_done", seen, 0);
        model_push(6, mlat, merr);
        run_op("rerun", 6, lat);
        chk("rerun_latency", lat, mlat);
        chk("rerun_err", err_bad_edge, merr);
        read_all_check("rerun");

        // ---------------- randomized runs ----------------
        for (int t = 0; t < 15; t++) begin
            int n;
            load_kind(3);
            for (int k = 0; k < 16; k++) begin
                if ($urandom_range(0, 9) < 9)
                    coo_mem[k] = ed($urandom_range(0, 5), $urandom_range(0, 5));
                else
                    coo_mem[k] = ed($urandom_range(0, 7), $urandom_range(6, 7));
            end
            n = $urandom_range(0, 20);
            model_push(n, mlat, merr);
            run_op($sformatf("rnd%0d", t), n, lat);
            chk($sformatf("rnd%0d_latency", t), lat, mlat);
            chk($sformatf("rnd%0d_err", t), err_bad_edge, merr);
            read_all_check($sformatf("rnd%0d", t));
        end

        // ---------------- final report ----------------
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
